dmem_ctrl: RTL and testbench

// Parametrised data-memory controller between TOP_CORE load/store outputs and word RAM storage.

---
 rtl/dmem_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory controller: RV32I byte/half/word loads and stores on word storage,
// with programmable wait states, a req/ready handshake and access-fault reporting.
module dmem_ctrl #(
  parameter int ANCHO       = 32,
  parameter int LARGO       = 1024,
  parameter int WAIT_STATES = 1,
  parameter     INIT_FILE   = ""
) (
  input  logic             CLOCK,
  input  logic             RST,
  input  logic             req,
  input  logic             we,
  input  logic [2:0]       funct3,
  input  logic [31:0]      addr,
  input  logic [ANCHO-1:0] din,
  output logic [ANCHO-1:0] dout,
  output logic             ready,
  output logic             fault
);

  localparam int ADDR_BITS = $clog2(LARGO);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_s;
  logic [3:0]             cnt_r;
  logic                   we_r;
  logic [2:0]             f3_r;
  logic [ADDR_BITS+1:0]   addr_r;
  logic [ANCHO-1:0]       din_r;
  logic [ANCHO-1:0]       dout_r;
  logic                   ready_r;
  logic                   fault_r;

  logic                   access_s;
  logic                   fault_s;
  logic                   wr_en_s;
  logic [ADDR_BITS-1:0]   word_idx_s;
  logic [1:0]             lane_s;
  logic [ANCHO-1:0]       rd_word_s;
  logic [7:0]             byte_s;
  logic [15:0]            half_s;
  logic [ANCHO-1:0]       load_s;
  logic [3:0]             be_s;
  logic [ANCHO-1:0]       wdata_s;

  logic [ANCHO-1:0]       mem_r [LARGO];

  // Rejects unknown width codes, unsigned stores and misaligned half/word accesses.
  function automatic logic access_fault(input logic is_store, input logic [2:0] f3,
                                        input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = lane[0];
      3'b010:  bad = (lane != 2'b00);
      3'b100:  bad = is_store;
      3'b101:  bad = is_store | lane[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  assign word_idx_s = addr_r[ADDR_BITS+1:2];
  assign lane_s     = addr_r[1:0];
  assign rd_word_s  = mem_r[word_idx_s];
  assign byte_s     = rd_word_s[{lane_s, 3'b000} +: 8];
  assign half_s     = lane_s[1] ? rd_word_s[31:16] : rd_word_s[15:0];
  assign fault_s    = access_fault(we_r, f3_r, lane_s);
  assign wr_en_s    = access_s & we_r & ~fault_s;

  // FSM state register.
  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; the access edge is the last BUSY cycle.
  always_comb begin
    state_s  = state_r;
    access_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (req) begin
          state_s = S_BUSY;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cnt_r == 4'd0) begin
          state_s  = S_RESP;
          access_s = 1'b1;
        end else begin
          state_s = S_BUSY;
        end
      end
      S_RESP:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Load extension from the captured width code.
  always_comb begin
    load_s = dout_r;
    case (f3_r)
      3'b000:  load_s = {{(ANCHO-8){byte_s[7]}}, byte_s};
      3'b100:  load_s = {{(ANCHO-8){1'b0}}, byte_s};
      3'b001:  load_s = {{(ANCHO-16){half_s[15]}}, half_s};
      3'b101:  load_s = {{(ANCHO-16){1'b0}}, half_s};
      3'b010:  load_s = rd_word_s;
      default: load_s = dout_r;
    endcase
  end

  // Store lanes: data is replicated so each enabled byte picks its own copy.
  always_comb begin
    be_s    = 4'b0000;
    wdata_s = din_r;
    case (f3_r)
      3'b000: begin
        be_s    = 4'b0001 << lane_s;
        wdata_s = {4{din_r[7:0]}};
      end
      3'b001: begin
        be_s    = lane_s[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{din_r[15:0]}};
      end
      3'b010: begin
        be_s    = 4'b1111;
        wdata_s = din_r;
      end
      default: begin
        be_s    = 4'b0000;
        wdata_s = din_r;
      end
    endcase
  end

  // Request capture, wait counter and registered outputs.
  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      f3_r    <= 3'b000;
      addr_r  <= '0;
      din_r   <= '0;
      dout_r  <= '0;
      ready_r <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      if ((state_r == S_IDLE) && req) begin
        cnt_r  <= 4'(WAIT_STATES);
        we_r   <= we;
        f3_r   <= funct3;
        addr_r <= addr[ADDR_BITS+1:0];
        din_r  <= din;
      end else if ((state_r == S_BUSY) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
      ready_r <= access_s;
      fault_r <= access_s & fault_s;
      if (access_s && !we_r && !fault_s) begin
        dout_r <= load_s;
      end
    end
  end

  // Byte-enable storage write; contents survive reset.
  always_ff @(posedge CLOCK) begin
    if (wr_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_r[word_idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
        end
      end
    end
  end

  assign dout  = dout_r;
  assign ready = ready_r;
  assign fault = fault_r;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed scoreboard bench for dmem_ctrl: one instance with no wait states,
// one with three, sharing clock, reset and request payload.
module tb_dmem_ctrl;

  logic        CLOCK = 1'b0;
  logic        RST;
  logic        req0, req3, we;
  logic [2:0]  funct3;
  logic [31:0] addr, din;
  logic [31:0] dout0, dout3;
  logic        ready0, ready3, fault0, fault3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] d;
    logic        f;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_dout [2];

  always #5 CLOCK = ~CLOCK;

  dmem_ctrl #(.ANCHO(32), .LARGO(1024), .WAIT_STATES(0), .INIT_FILE("")) dut0 (
    .CLOCK(CLOCK), .RST(RST), .req(req0), .we(we), .funct3(funct3), .addr(addr),
    .din(din), .dout(dout0), .ready(ready0), .fault(fault0)
  );

  dmem_ctrl #(.ANCHO(32), .LARGO(1024), .WAIT_STATES(3), .INIT_FILE("")) dut3 (
    .CLOCK(CLOCK), .RST(RST), .req(req3), .we(we), .funct3(funct3), .addr(addr),
    .din(din), .dout(dout3), .ready(ready3), .fault(fault3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction: drive at a negedge, accept on the next posedge, scramble
  // inputs, wait for ready (bounded), then check the response and pulse width.
  task automatic access(input int sel, input string tag, input logic w, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d, input logic exp_fault,
                        input logic [31:0] exp_load, input bit toggle);
    exp_t        e;
    exp_t        got;
    int          n;
    bit          seen;
    logic        rdy;
    logic [31:0] od;
    logic        of;
    if (!w && !exp_fault) model_dout[sel] = exp_load;
    e.d   = model_dout[sel];
    e.f   = exp_fault;
    e.tag = tag;
    we = w; funct3 = f; addr = a; din = d;
    if (sel == 0) req0 = 1'b1; else req3 = 1'b1;
    @(posedge CLOCK);
    sb_q.push_back(e);
    #1;
    req0 = 1'b0; req3 = 1'b0;
    we = ~w; funct3 = 3'b111; addr = $urandom; din = $urandom;
    seen = 1'b0; n = 0; od = '0; of = 1'b0;
    while (!seen && n < 20) begin
      @(negedge CLOCK);
      n++;
      rdy = (sel == 0) ? ready0 : ready3;
      od  = (sel == 0) ? dout0  : dout3;
      of  = (sel == 0) ? fault0 : fault3;
      if (rdy === 1'b1) seen = 1'b1;
      if (toggle && sel != 0) req3 = (n == 1 || n == 3);
    end
    req3 = 1'b0;
    check({tag, "_latency"}, 32'(n), (sel == 0) ? 32'd2 : 32'd5);
    got = sb_q.pop_front();
    check({got.tag, "_dout"}, od, got.d);
    check({got.tag, "_fault"}, {31'd0, of}, {31'd0, got.f});
    @(negedge CLOCK);
    rdy = (sel == 0) ? ready0 : ready3;
    of  = (sel == 0) ? fault0 : fault3;
    check({tag, "_ready_pulse"}, {31'd0, rdy}, 32'd0);
    check({tag, "_fault_idle"}, {31'd0, of}, 32'd0);
  endtask

  initial begin
    bit extra;
    RST = 1'b1; req0 = 1'b0; req3 = 1'b0; we = 1'b0; funct3 = 3'b000;
    addr = 32'd0; din = 32'd0;
    model_dout[0] = 32'd0; model_dout[1] = 32'd0;
    repeat (2) @(negedge CLOCK);
    check("rst_dout0", dout0, 32'd0);
    check("rst_ready0", {31'd0, ready0}, 32'd0);
    check("rst_fault0", {31'd0, fault0}, 32'd0);
    check("rst_dout3", dout3, 32'd0);
    check("rst_ready3", {31'd0, ready3}, 32'd0);
    RST = 1'b0;
    @(negedge CLOCK);
    check("idle_ready0", {31'd0, ready0}, 32'd0);

    // Word store/load round trip
    access(0, "t1_sw", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    access(0, "t1_lw", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);

    // Byte merge and extension
    access(0, "t2_sw", 1'b1, 3'b010, 32'h10, 32'h11223344, 1'b0, 32'h0, 1'b0);
    access(0, "t2_sb", 1'b1, 3'b000, 32'h13, 32'h12345680, 1'b0, 32'h0, 1'b0);
    access(0, "t2_lw", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h80223344, 1'b0);
    access(0, "t2_lb", 1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'hFFFFFF80, 1'b0);
    access(0, "t2_lbu", 1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 32'h00000080, 1'b0);
    access(0, "t2_lb1", 1'b0, 3'b000, 32'h11, 32'h0, 1'b0, 32'h00000033, 1'b0);

    // Halfword merge and extension
    access(0, "t3_sw", 1'b1, 3'b010, 32'h20, 32'h0, 1'b0, 32'h0, 1'b0);
    access(0, "t3_sh", 1'b1, 3'b001, 32'h22, 32'h7777A5A5, 1'b0, 32'h0, 1'b0);
    access(0, "t3_lw", 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'hA5A50000, 1'b0);
    access(0, "t3_lh", 1'b0, 3'b001, 32'h22, 32'h0, 1'b0, 32'hFFFFA5A5, 1'b0);
    access(0, "t3_lhu", 1'b0, 3'b101, 32'h22, 32'h0, 1'b0, 32'h0000A5A5, 1'b0);
    access(0, "t3_lh0", 1'b0, 3'b001, 32'h20, 32'h0, 1'b0, 32'h00000000, 1'b0);

    // Faults leave storage and dout untouched
    access(0, "t4_lw_mis", 1'b0, 3'b010, 32'h11, 32'h0, 1'b1, 32'h0, 1'b0);
    access(0, "t4_sh_mis", 1'b1, 3'b001, 32'h23, 32'h0000FFFF, 1'b1, 32'h0, 1'b0);
    access(0, "t4_f3_011", 1'b0, 3'b011, 32'h20, 32'h0, 1'b1, 32'h0, 1'b0);
    access(0, "t4_sbu", 1'b1, 3'b100, 32'h10, 32'h00000000, 1'b1, 32'h0, 1'b0);
    access(0, "t4_lw20", 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'hA5A50000, 1'b0);
    access(0, "t4_lw10", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h80223344, 1'b0);

    // Three wait states, req toggled while busy
    access(1, "t5_sw", 1'b1, 3'b010, 32'h8, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
    access(1, "t5_lw", 1'b0, 3'b010, 32'h8, 32'h0, 1'b0, 32'hCAFEF00D, 1'b1);
    extra = 1'b0;
    repeat (8) begin
      @(negedge CLOCK);
      if (ready3 === 1'b1) extra = 1'b1;
    end
    check("t5_no_extra", {31'd0, extra}, 32'd0);

    // Reset aborts an in-flight store; address wraps modulo depth
    access(0, "t6_sw", 1'b1, 3'b010, 32'h40, 32'h12345678, 1'b0, 32'h0, 1'b0);
    access(0, "t6_lw", 1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 32'h12345678, 1'b0);
    we = 1'b1; funct3 = 3'b010; addr = 32'h40; din = 32'hBADBAD00; req0 = 1'b1;
    @(posedge CLOCK);
    #2;
    RST = 1'b1;
    req0 = 1'b0;
    #1;
    check("t6_rst_ready", {31'd0, ready0}, 32'd0);
    check("t6_rst_fault", {31'd0, fault0}, 32'd0);
    check("t6_rst_dout0", dout0, 32'd0);
    check("t6_rst_dout3", dout3, 32'd0);
    model_dout[0] = 32'd0;
    model_dout[1] = 32'd0;
    @(negedge CLOCK);
    @(negedge CLOCK);
    RST = 1'b0;
    access(0, "t6_wrap", 1'b0, 3'b010, 32'h40 + 32'd4096, 32'h0, 1'b0, 32'h12345678, 1'b0);
    access(0, "t6_hi", 1'b0, 3'b010, 32'h80000040, 32'h0, 1'b0, 32'h12345678, 1'b0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
